// File: rtl/mul_seq32.sv
// mul_seq32 - sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU).
//
// It multiplies the operand magnitudes with a radix-2 shift-add loop. Each
// cycle does one 32-bit add-with-carry. A sign fix-up is applied at the end,
// and the selected 32-bit half of the product is returned.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready == IDLE)
//   op                   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   src1, src2           multiplicand / multiplier, sampled on acceptance
//   flush                kills any in-flight operation; blocks acceptance in IDLE
//   out_valid/out_ready  result handshake (out_valid == DONE)
//   result               low word (MUL) or high word (others), set on FIX edge
//
// Optional feature: define MUL_ZERO_SKIP_EN to finish in one cycle when
// either operand is zero.
module mul_seq32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [32:0] acc_hi_q, acc_hi_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic        src1_neg, src2_neg;
    logic [31:0] src1_mag, src2_mag;
    logic [32:0] sum33, step;
    logic [63:0] prod64, prod_fix;

    // Operand signedness and magnitudes. Negating 0x80000000 gives
    // 0x80000000 again, which is the correct unsigned magnitude.
    assign src1_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && src1[31];
    assign src2_neg = (op == OP_MULH) && src2[31];
    assign src1_mag = src1_neg ? (~src1 + 32'd1) : src1;
    assign src2_mag = src2_neg ? (~src2 + 32'd1) : src2;

    // acc_hi[32] is always zero between steps. Adding the full 33 bits
    // therefore gives the same value as {c,sum} = acc_hi[31:0] + mcand.
    assign sum33    = acc_hi_q + {1'b0, mcand_q};
    assign step     = mplier_q[0] ? sum33 : {1'b0, acc_hi_q[31:0]};

    assign prod64   = {acc_hi_q[31:0], mplier_q};
    assign prod_fix = neg_q ? (~prod64 + 64'd1) : prod64;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (flush && (state_q != IDLE)) begin
            // Drop the operation; result keeps its previous value.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_d     = op;
                        neg_d    = src1_neg ^ src2_neg;
                        mcand_d  = src1_mag;
                        mplier_d = src2_mag;
                        acc_hi_d = '0;
                        cnt_d    = '0;
                        state_d  = BUSY;
`ifdef MUL_ZERO_SKIP_EN
                        if ((src1 == 32'd0) || (src2 == 32'd0)) begin
                            result_d = '0;
                            state_d  = DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    // {acc_hi, mplier} <= {c, sum, mplier} >> 1
                    acc_hi_d = {1'b0, step[32:1]};
                    mplier_d = {step[0], mplier_q[31:1]};
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_d = FIX;
                end
                FIX: begin
                    result_d = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
                    state_d  = DONE;
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule
